// File: rtl/spi_master.sv
// SPI mode-0 master: {rw, addr, data} frame, MSB first, full-duplex receive into rdata.
// Optional macro SPI_MASTER_BUSY_ERR_EN enables the sticky start-while-busy err flag.
module spi_master #(
  parameter int DIV    = 2,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  output logic              ready,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              done,
  output logic              err,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);
  localparam int FRAME = 8 + WIDTH;
  localparam int BCW   = $clog2(FRAME + 1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, DONE} state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
  } req_t;

  state_t           state, state_nxt;
  req_t             req;
  logic [7:0]       div_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic [FRAME-1:0] tx_sr, frame;
  logic [WIDTH-1:0] rx_sr;
  logic [7:0]       hdr;
  logic             tick, first, accept;

  assign req    = '{rw: rw, addr: addr, wdata: wdata};
  assign tick   = (div_cnt == 8'd0);
  assign first  = (div_cnt == 8'(DIV - 1));
  assign accept = start && ready;

  // Header byte: rw in the MSB, address right-aligned, zero padding between.
  always_comb begin
    hdr    = 8'(req.addr);
    hdr[7] = req.rw;
    frame  = {hdr, req.rw ? req.wdata : {WIDTH{1'b0}}};
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    spi_cs_n  = 1'b0;
    spi_clk   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready    = 1'b1;
        spi_cs_n = 1'b1;
        if (start) state_nxt = LEAD;
      end
      LEAD: if (tick) state_nxt = HIGH;
      HIGH: begin
        spi_clk = 1'b1;
        if (tick) state_nxt = LOW;
      end
      LOW: if (tick) state_nxt = (bit_cnt == BCW'(FRAME)) ? DONE : HIGH;
      DONE: begin
        ready     = 1'b1;
        spi_cs_n  = 1'b1;
        done      = 1'b1;
        state_nxt = start ? LEAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign spi_mosi = (state == LEAD || state == HIGH || state == LOW) ? tx_sr[FRAME-1] : 1'b0;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div_cnt <= 8'd0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rdata   <= '0;
    end else begin
      if (state_nxt != state) div_cnt <= 8'(DIV - 1);
      else if (!tick)         div_cnt <= div_cnt - 8'd1;
      // MOSI advances as SCLK falls, i.e. on leaving HIGH.
      if (accept) begin
        tx_sr   <= frame;
        bit_cnt <= '0;
      end else if (state == HIGH && tick) begin
        tx_sr   <= tx_sr << 1;
        bit_cnt <= bit_cnt + BCW'(1);
      end
      if (state == HIGH && first) rx_sr <= WIDTH'({rx_sr, spi_miso});
      if (state == LOW && state_nxt == DONE) rdata <= rx_sr;
    end
  end

`ifdef SPI_MASTER_BUSY_ERR_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                err <= 1'b0;
    else if (start && !ready) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: default instance (DIV=2) plus a DIV=1 instance.
module tb_spi_master;
  logic clk = 1'b0, rstb = 1'b0;
  always #5 clk = ~clk;

  logic       start = 0, rw = 0, ready, done, err, spi_cs_n, spi_clk, spi_mosi, spi_miso = 0;
  logic [2:0] addr = 0;
  logic [7:0] wdata = 0, rdata;
  logic       start1 = 0, rw1 = 0, ready1, done1, err1, cs1_n, sclk1, mosi1, miso1 = 0;
  logic [2:0] addr1 = 0;
  logic [7:0] wdata1 = 0, rdata1;

  spi_master u_dut (
    .clk(clk), .rstb(rstb), .start(start), .ready(ready), .rw(rw), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .spi_cs_n(spi_cs_n),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso));

  spi_master #(.DIV(1)) u_dut1 (
    .clk(clk), .rstb(rstb), .start(start1), .ready(ready1), .rw(rw1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .done(done1), .err(err1), .spi_cs_n(cs1_n),
    .spi_clk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1));

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int vectors = 0, miscompares = 0;

`ifdef SPI_MASTER_BUSY_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  // Peripheral models: capture MOSI on rising SCLK, shift MISO out on falling SCLK.
  logic [15:0] cap0 = 0, cap1 = 0, mword0 = 0, mword1 = 0;
  int nedge0 = 0, nedge1 = 0, midx0 = -1, midx1 = -1;

  always @(negedge spi_cs_n) begin cap0 = 0; nedge0 = 0; spi_miso = mword0[15]; midx0 = 14; end
  always @(posedge spi_clk) begin cap0 = {cap0[14:0], spi_mosi}; nedge0++; end
  always @(negedge spi_clk) if (midx0 >= 0) begin spi_miso = mword0[midx0]; midx0--; end

  always @(negedge cs1_n) begin cap1 = 0; nedge1 = 0; miso1 = mword1[15]; midx1 = 14; end
  always @(posedge sclk1) begin cap1 = {cap1[14:0], mosi1}; nedge1++; end
  always @(negedge sclk1) if (midx1 >= 0) begin miso1 = mword1[midx1]; midx1--; end

  // Drives one request into cycle 0, then scrambles the inputs; returns at cycle 1.
  task automatic start_xfer(input logic r, input logic [2:0] a, input logic [7:0] d,
                            input logic [15:0] mw);
    @(negedge clk);
    rw = r; addr = a; wdata = d; mword0 = mw; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rw = ~r; addr = ~a; wdata = ~d;
  endtask

  // Counts cycles from the current one (=1) until done; bounded.
  task automatic wait_done(output int cyc, output int cs_hi, output int rdy_hi);
    cyc = 1; cs_hi = 0; rdy_hi = 0;
    while (!done && cyc < 400) begin
      if (spi_cs_n) cs_hi++;
      if (ready) rdy_hi++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++; if ({spi_cs_n, spi_clk, spi_mosi, ready, done} !== 5'b10010) begin
      miscompares++; $display("FAIL reset_pins: got %b want 10010", {spi_cs_n, spi_clk, spi_mosi, ready, done}); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    vectors++; if ({cs1_n, sclk1, mosi1, ready1, done1, rdata1} !== {5'b10010, 8'h00}) begin
      miscompares++; $display("FAIL reset_div1: got %b want 1001000000000", {cs1_n, sclk1, mosi1, ready1, done1, rdata1}); end
    rstb = 1'b1;
  endtask

  task automatic check_frame(input string nm, input int c, input int hi, input int rh);
    exp_t e;
    e = sb.pop_front();
    vectors++; if (c !== e.cyc) begin miscompares++; $display("FAIL %s_done_cycle: got %0d want %0d", nm, c, e.cyc); end
    vectors++; if (hi !== 0 || rh !== 0) begin miscompares++; $display("FAIL %s_cs_ready_busy: got cs_hi=%0d rdy_hi=%0d want 0", nm, hi, rh); end
    vectors++; if (cap0 !== e.frame || nedge0 !== 16) begin
      miscompares++; $display("FAIL %s_mosi: got %h (%0d edges) want %h (16 edges)", nm, cap0, nedge0, e.frame); end
    vectors++; if (rdata !== e.rdata) begin miscompares++; $display("FAIL %s_rdata: got %h want %h", nm, rdata, e.rdata); end
    vectors++; if (spi_cs_n !== 1'b1 || ready !== 1'b1) begin
      miscompares++; $display("FAIL %s_done_state: got cs_n=%b ready=%b want 1 1", nm, spi_cs_n, ready); end
  endtask

  task automatic test_write;
    int c, hi, rh;
    sb.push_back('{16'h85A5, 8'h34, 67});
    start_xfer(1'b1, 3'd5, 8'hA5, 16'h1234);
    wait_done(c, hi, rh);
    check_frame("write", c, hi, rh);
    @(negedge clk);
    vectors++; if (done !== 1'b0 || err !== 1'b0) begin
      miscompares++; $display("FAIL write_after: got done=%b err=%b want 0 0", done, err); end
  endtask

  task automatic test_read;
    int c, hi, rh;
    sb.push_back('{16'h0200, 8'h3C, 67});
    start_xfer(1'b0, 3'd2, 8'hFF, 16'hC33C);
    wait_done(c, hi, rh);
    check_frame("read", c, hi, rh);
  endtask

  task automatic test_busy;
    int c, hi, rh;
    sb.push_back('{16'h843E, 8'h0F, 67});
    start_xfer(1'b1, 3'd4, 8'h3E, 16'h0F0F);
    repeat (19) @(negedge clk);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL busy_err_pre: got %b want 0", err); end
    start = 1'b1; rw = 1'b0; addr = 3'd1; wdata = 8'h00;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (err !== ERR_EXP) begin miscompares++; $display("FAIL busy_err: got %b want %b", err, ERR_EXP); end
    wait_done(c, hi, rh);
    check_frame("busy", c + 20, hi, rh);
    vectors++; if (err !== ERR_EXP) begin miscompares++; $display("FAIL busy_err_sticky: got %b want %b", err, ERR_EXP); end
  endtask

  task automatic test_back_to_back;
    int c, hi, rh;
    sb.push_back('{16'h835A, 8'hC7, 67});
    sb.push_back('{16'h0600, 8'h96, 67});
    @(negedge clk);
    rw = 1'b1; addr = 3'd3; wdata = 8'h5A; mword0 = 16'h00C7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rw = 1'b0; addr = 3'd6; wdata = 8'h11;
    wait_done(c, hi, rh);
    mword0 = 16'hAB96;
    check_frame("b2b_first", c, hi, rh);
    @(negedge clk);
    start = 1'b0;
    vectors++; if (spi_cs_n !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL b2b_gap: got cs_n=%b done=%b want 0 0", spi_cs_n, done); end
    wait_done(c, hi, rh);
    check_frame("b2b_second", c, hi, rh);
  endtask

  task automatic test_reset_abort;
    int c, hi, rh, dseen;
    start_xfer(1'b1, 3'd6, 8'h77, 16'hFFFF);
    repeat (29) @(negedge clk);
    rstb = 1'b0;
    #1;
    vectors++; if ({spi_cs_n, spi_clk, spi_mosi, ready, done, err, rdata} !== {6'b100100, 8'h00}) begin
      miscompares++; $display("FAIL abort_state: got %b want 10010000000000", {spi_cs_n, spi_clk, spi_mosi, ready, done, err, rdata}); end
    dseen = 0;
    repeat (3) begin @(negedge clk); if (done) dseen++; end
    vectors++; if (dseen !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", dseen); end
    sb.push_back('{16'h81C3, 8'hAA, 67});
    rstb = 1'b1; rw = 1'b1; addr = 3'd1; wdata = 8'hC3; mword0 = 16'h55AA; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(c, hi, rh);
    check_frame("post_abort", c, hi, rh);
  endtask

  task automatic test_div1;
    int c, bad;
    @(negedge clk);
    rw1 = 1'b1; addr1 = 3'd7; wdata1 = 8'hFF; mword1 = 16'h6C6C; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; wdata1 = 8'h00;
    c = 1; bad = 0;
    while (!done1 && c < 200) begin
      if (sclk1 !== ((c % 2 == 0) ? 1'b1 : 1'b0)) bad++;
      @(negedge clk);
      c++;
    end
    vectors++; if (c !== 34) begin miscompares++; $display("FAIL div1_done_cycle: got %0d want 34", c); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL div1_sclk: got %0d bad cycles want 0", bad); end
    vectors++; if (cap1 !== 16'h87FF || nedge1 !== 16) begin
      miscompares++; $display("FAIL div1_mosi: got %h (%0d edges) want 87ff (16 edges)", cap1, nedge1); end
    vectors++; if (rdata1 !== 8'h6C) begin miscompares++; $display("FAIL div1_rdata: got %h want 6c", rdata1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write;
    test_read;
    test_busy;
    test_back_to_back;
    test_reset_abort;
    test_div1;
    vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows.
- DIV, 2: SCLK half-period in clk cycles; legal range 1..255.
- WIDTH, 8: data field width in bits.
- ADDR_W, 3: register address width; legal range 1..7.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows.
- clk, in, 1: single system clock; all state changes on its rising edge.
- rstb, in, 1: asynchronous, active-low reset.
- start, in, 1: transaction request.
- ready, out, 1: idle, can accept start.
- rw, in, 1: 1=write, 0=read.
- addr, in, ADDR_W: target register address.
- wdata, in, WIDTH: write data.
- rdata, out, WIDTH: last received data field.
- done, out, 1: one-cycle completion pulse.
- err, out, 1: sticky start-while-busy flag.
- spi_cs_n, out, 1: chip select, active low.
- spi_clk, out, 1: SCLK.
- spi_mosi, out, 1: serial data to peripheral.
- spi_miso, in, 1: serial data from peripheral.

Function
REQ-003 Protocol SHALL be SPI mode 0 (CPOL=0, CPHA=0), MSB first, with FRAME = 8+WIDTH bits per transaction.
REQ-004 The frame SHALL be {rw, (7-ADDR_W) zero bits, addr, wdata}; for reads the wdata field is transmitted as zeros.
REQ-005 rw, addr and wdata SHALL be captured into a shift register in the cycle start && ready is sampled (cycle 0); later input changes SHALL NOT affect the frame.
REQ-006 The state machine SHALL have the states IDLE, LEAD, HIGH, LOW and DONE.
- IDLE: on start, go to LEAD.
- LEAD: DIV cycles, then HIGH.
- HIGH: DIV cycles, then LOW.
- LOW: DIV cycles, then HIGH if bits remain, else DONE.
- DONE: one cycle, then IDLE.
REQ-007 Output levels per state SHALL be as follows.
- IDLE: spi_cs_n=1, spi_clk=0, ready=1.
- LEAD, HIGH, LOW: spi_cs_n=0, ready=0.
- HIGH: spi_clk=1.
- LEAD, LOW, DONE: spi_clk=0.
- DONE: spi_cs_n=1, done=1, ready=1.
REQ-008 spi_mosi SHALL present frame bit FRAME-1 from cycle 1 and SHALL advance to the next bit in the first cycle of each LOW→HIGH transition predecessor, i.e. on the SCLK falling edge; it SHALL be 0 in IDLE.
REQ-009 spi_miso SHALL be sampled into the receive shift register in the first cycle of each HIGH state (SCLK rising edge), giving exactly FRAME samples.
REQ-010 On entry to DONE, rdata SHALL load the last WIDTH sampled bits for both reads and writes; rdata SHALL otherwise hold its value.
REQ-011 done SHALL assert exactly in cycle 1+DIV*(1+2*FRAME) after cycle 0, which is cycle 67 for the defaults.
REQ-012 Because ready=1 in DONE, a start sampled in DONE SHALL begin a new transaction with spi_cs_n high for exactly one cycle; done and the new LEAD SHALL NOT overlap.
REQ-013 start while ready=0 SHALL be ignored with no effect on the transfer in progress.
REQ-014 A bit counter SHALL count FRAME bits exactly, and the divider counter SHALL reload at every state change; DIV=1 SHALL yield SCLK at clk/2.

Reset
REQ-015 While rstb=0, the block SHALL be in IDLE with spi_cs_n=1, spi_clk=0, spi_mosi=0, ready=1, done=0, err=0, rdata=0, and all counters and shift registers cleared.
REQ-016 Reset asserted mid-transaction SHALL abort it immediately with no done pulse and rdata=0; after release, the block SHALL accept start in the first clock cycle.

Configuration
REQ-017 Macro SPI_MASTER_BUSY_ERR_EN SHALL select the err behaviour.
- Defined: err sets in the cycle after start=1 is sampled with ready=0, and stays set until reset.
- Undefined: err is tied to 0 and no error logic is synthesized.
- Either way, REQ-013 holds.

Verification
REQ-018 Write, defaults: rw=1, addr=5, wdata=0xA5 → MOSI carries 0x85A5 on 16 rising SCLK edges; cs_n low cycles 1..66; done=1 at cycle 67.
REQ-019 Read: rw=0, addr=2, MISO model returns 0x3C in the data field → frame 0x0200 on MOSI; rdata=0x3C at done.
REQ-020 Back-to-back: start held high → cs_n high exactly one cycle between frames; two done pulses 67 cycles apart.
REQ-021 Busy start: start pulsed at cycle 20 → frame unchanged; err=1 from cycle 21 with SPI_MASTER_BUSY_ERR_EN defined, err=0 without it.
REQ-022 Reset abort: rstb low at cycle 30 → cs_n=1, spi_clk=0, no done; a new write after release completes correctly.
REQ-023 DIV=1: write rw=1, addr=7, wdata=0xFF → SCLK period 2 clk; done at cycle 34; MOSI frame 0x87FF.
